// File: rtl/llc_pkg.sv
// Shared definitions for the LLC trace sequencer: trace command codes,
// sequencer FSM states and hit-ratio fixed-point scaling.
package llc_pkg;

  localparam int CMDSIZE     = 4;
  localparam int ADDR_BITS   = 32;
  localparam int RATIO_W     = 14;
  localparam int RATIO_SCALE = 10000;

  typedef enum logic [3:0] {
    CMD_RD    = 4'd0,
    CMD_WR    = 4'd1,
    CMD_IRD   = 4'd2,
    CMD_SINV  = 4'd3,
    CMD_SRD   = 4'd4,
    CMD_SWR   = 4'd5,
    CMD_SRWIM = 4'd6,
    CMD_CLR   = 4'd8,
    CMD_PRT   = 4'd9
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DIVIDE,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/llc_ratio_div.sv
// Serial restoring unsigned divider: one quotient bit per cycle, fixed NUM_W
// cycle latency from start to done. A zero divisor yields a zero quotient.
module llc_ratio_div #(
  parameter int NUM_W = 46,
  parameter int DEN_W = 33,
  parameter int Q_W   = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int CNT_BITS = $clog2(NUM_W + 1);

  logic [DEN_W:0]      rem_reg;
  logic [NUM_W-1:0]    quo_reg;
  logic [DEN_W-1:0]    den_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                zero_reg;

  logic [DEN_W:0] rem_shift;
  logic [DEN_W:0] rem_sub;
  logic           rem_ge;

  // The dividend is shifted out of the top of quo_reg while quotient bits fill the bottom.
  assign rem_shift = {rem_reg[DEN_W-1:0], quo_reg[NUM_W-1]};
  assign rem_ge    = rem_shift >= {1'b0, den_reg};
  assign rem_sub   = rem_shift - {1'b0, den_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      den_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      zero_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= '0;
      quo_reg  <= num;
      den_reg  <= den;
      zero_reg <= (den == '0);
      cnt_reg  <= CNT_BITS'(NUM_W);
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      rem_reg <= rem_ge ? rem_sub : rem_shift;
      quo_reg <= {quo_reg[NUM_W-2:0], rem_ge};
      cnt_reg <= cnt_reg - CNT_BITS'(1);
      if (cnt_reg == CNT_BITS'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign quot = zero_reg ? '0 : quo_reg[Q_W-1:0];

endmodule

// File: rtl/llc_trace_sequencer.sv
// Buffers trace records, dispatches LLC commands to address-interleaved
// channels (one outstanding each) and runs clear/print control commands.
module llc_trace_sequencer
  import llc_pkg::*;
#(
  parameter int CMDSIZE    = llc_pkg::CMDSIZE,
  parameter int ADDR_BITS  = llc_pkg::ADDR_BITS,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_SEL_LSB = 6,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CMDSIZE-1:0]          in_cmd,
  input  logic [ADDR_BITS-1:0]        in_addr,
  input  logic                        mode_silent,
  output logic [NUM_CH-1:0]           llc_valid,
  input  logic [NUM_CH-1:0]           llc_ready,
  output logic [NUM_CH*CMDSIZE-1:0]   llc_cmd,
  output logic [NUM_CH*ADDR_BITS-1:0] llc_addr,
  input  logic [NUM_CH-1:0]           rsp_valid,
  input  logic [NUM_CH-1:0]           rsp_hit,
  output logic                        clear_pulse,
  output logic                        print_pulse,
  output logic [CNT_W-1:0]            reads,
  output logic [CNT_W-1:0]            writes,
  output logic [CNT_W-1:0]            hits,
  output logic [CNT_W-1:0]            misses,
  output logic [RATIO_W-1:0]          hit_ratio
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REC_W = CMDSIZE + ADDR_BITS;
  localparam int NUM_W = CNT_W + RATIO_W;
  localparam int DEN_W = CNT_W + 1;

  // ---------------- input FIFO ----------------
  logic [REC_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_reg;
  logic [PTR_W:0]       rd_ptr_reg;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [CMDSIZE-1:0]   head_cmd;
  logic [ADDR_BITS-1:0] head_addr;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign {head_cmd, head_addr} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {in_cmd, in_addr};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------- head decode ----------------
  logic [CH_W-1:0] head_ch;
  logic            is_llc;
  logic            is_ctrl;
  logic            is_counted;
  logic            is_read;
  logic            is_write;

  if (NUM_CH == 1) begin : g_one_ch
    assign head_ch = '0;
  end else begin : g_multi_ch
    assign head_ch = head_addr[CH_SEL_LSB +: CH_W];
  end

  assign is_llc     = head_cmd <= CMDSIZE'(CMD_SRWIM);
  assign is_ctrl    = (head_cmd == CMDSIZE'(CMD_CLR)) || (head_cmd == CMDSIZE'(CMD_PRT));
  assign is_counted = head_cmd <= CMDSIZE'(CMD_IRD);
  assign is_read    = (head_cmd == CMDSIZE'(CMD_RD)) || (head_cmd == CMDSIZE'(CMD_IRD));
  assign is_write   = (head_cmd == CMDSIZE'(CMD_WR));

  // ---------------- FSM ----------------
  state_e              state_reg;
  state_e              state_next;
  logic                issue_valid;
  logic                accept;
  logic                ch_free;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [RATIO_W-1:0]  div_quot;
  logic [NUM_CH-1:0]   busy_reg;
  logic [NUM_CH-1:0]   counted_reg;

  assign ch_free = !busy_reg[head_ch];
  assign accept  = issue_valid && llc_ready[head_ch];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The request is offered from IDLE already, giving one-cycle push-to-valid latency.
  always_comb begin
    state_next  = state_reg;
    issue_valid = 1'b0;
    pop         = 1'b0;
    div_start   = 1'b0;
    clear_pulse = 1'b0;
    print_pulse = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          if (is_llc) begin
            issue_valid = ch_free;
            if (ch_free && llc_ready[head_ch]) begin
              pop = 1'b1;
            end else begin
              state_next = ST_ISSUE;
            end
          end else if (is_ctrl) begin
            state_next = ST_DRAIN;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        issue_valid = ch_free;
        if (ch_free && llc_ready[head_ch]) begin
          pop        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((busy_reg == '0) && !div_busy) begin
          div_start  = 1'b1;
          state_next = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        pop         = 1'b1;
        state_next  = ST_IDLE;
        clear_pulse = (head_cmd == CMDSIZE'(CMD_CLR));
        print_pulse = (head_cmd == CMDSIZE'(CMD_PRT)) && !mode_silent;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- per-channel request/response ----------------
  logic [NUM_CH-1:0] acc_vec;
  logic [NUM_CH-1:0] rsp_live;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign llc_valid[gi] = issue_valid && (head_ch == CH_W'(gi));
    assign llc_cmd[gi*CMDSIZE +: CMDSIZE]      = llc_valid[gi] ? head_cmd : '0;
    assign llc_addr[gi*ADDR_BITS +: ADDR_BITS] = llc_valid[gi] ? head_addr : '0;
    assign acc_vec[gi]  = llc_valid[gi] && llc_ready[gi];
    assign rsp_live[gi] = rsp_valid[gi] && busy_reg[gi] && counted_reg[gi];
  end

  // A new accept dominates a same-cycle response so the new request stays outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg    <= '0;
      counted_reg <= '0;
    end else begin
      busy_reg    <= acc_vec | (busy_reg & ~rsp_valid);
      counted_reg <= (acc_vec & {NUM_CH{is_counted}}) | (counted_reg & ~acc_vec);
    end
  end

  // ---------------- statistics ----------------
  logic [CNT_W-1:0]   reads_reg;
  logic [CNT_W-1:0]   writes_reg;
  logic [CNT_W-1:0]   hits_reg;
  logic [CNT_W-1:0]   misses_reg;
  logic [RATIO_W-1:0] ratio_reg;
  logic [CNT_W-1:0]   hit_inc;
  logic [CNT_W-1:0]   miss_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    hit_inc  = '0;
    miss_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rsp_live[c]) begin
        if (rsp_hit[c]) hit_inc  = hit_inc + CNT_W'(1);
        else            miss_inc = miss_inc + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reads_reg  <= '0;
      writes_reg <= '0;
      hits_reg   <= '0;
      misses_reg <= '0;
      ratio_reg  <= '0;
    end else if (clear_pulse) begin
      reads_reg  <= '0;
      writes_reg <= '0;
      hits_reg   <= '0;
      misses_reg <= '0;
      ratio_reg  <= '0;
    end else begin
      if (accept && is_read)  reads_reg  <= sat_add(reads_reg, CNT_W'(1));
      if (accept && is_write) writes_reg <= sat_add(writes_reg, CNT_W'(1));
      hits_reg   <= sat_add(hits_reg, hit_inc);
      misses_reg <= sat_add(misses_reg, miss_inc);
      if (div_done) ratio_reg <= div_quot;
    end
  end

  assign reads     = reads_reg;
  assign writes    = writes_reg;
  assign hits      = hits_reg;
  assign misses    = misses_reg;
  assign hit_ratio = ratio_reg;

  llc_ratio_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .Q_W   (RATIO_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (NUM_W'(hits_reg) * NUM_W'(RATIO_SCALE)),
    .den   (DEN_W'(hits_reg) + DEN_W'(misses_reg)),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

endmodule
